// File: rtl/mips_defs.sv
// Shared MIPS opcode constants, instruction classes and decode bundle
// used by the dual-issue scheduler.
package mips_defs;

    localparam logic [5:0] OP_RT    = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2
    } iclass_e;

    typedef struct packed {
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        iclass_e    cls;
    } dec_t;

    // $0 is hard-wired, so a match on it is never a hazard.
    function automatic logic src_hits(dec_t x, logic [4:0] r);
        return (r != 5'd0) &&
               ((x.rs_used && x.rs == r) || (x.rt_used && x.rt == r));
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of one instruction into destination, used
// sources and issue class.
module instr_decode
    import mips_defs::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [5:0] op;
    logic       unused_bits;

    assign op          = instr_i[31:26];
    assign unused_bits = ^instr_i[10:0];

    always_comb begin
        dec_o         = '0;
        dec_o.rs      = instr_i[25:21];
        dec_o.rt      = instr_i[20:16];
        dec_o.rs_used = 1'b1;
        dec_o.cls     = CLS_ALU;
        unique case (op)
            OP_RT: begin
                dec_o.dest    = instr_i[15:11];
                dec_o.rt_used = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_SLTI, OP_SLTIU: begin
                dec_o.dest = instr_i[20:16];
            end
            OP_LUI: begin
                dec_o.dest    = instr_i[20:16];
                dec_o.rs_used = 1'b0;
            end
            OP_LW: begin
                dec_o.dest = instr_i[20:16];
                dec_o.cls  = CLS_MEM;
            end
            OP_SW: begin
                dec_o.rt_used = 1'b1;
                dec_o.cls     = CLS_MEM;
            end
            OP_BEQ, OP_BNE: begin
                dec_o.rt_used = 1'b1;
                dec_o.cls     = CLS_BR;
            end
            OP_J: begin
                dec_o.rs_used = 1'b0;
                dec_o.cls     = CLS_BR;
            end
            OP_JAL: begin
                dec_o.dest    = 5'd31;
                dec_o.rs_used = 1'b0;
                dec_o.cls     = CLS_BR;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: instruction FIFO, pairing/steering
// logic and a per-lane E/M/WB destination scoreboard.
module dual_issue_scheduler
    import mips_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid1,
    input  logic             in_valid2,
    input  logic [31:0]      in_instr1,
    input  logic [31:0]      in_instr2,
    output logic             in_ready,
    input  logic             hold,
    input  logic             flush,
    output logic             iss_valid1,
    output logic             iss_valid2,
    output logic [31:0]      iss_instr1,
    output logic [31:0]      iss_instr2,
    output logic [PTR_W:0]   occupancy
);

    localparam logic [PTR_W:0] FILL_MAX = (PTR_W + 1)'(DEPTH - 2);

    logic [31:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     cnt_q, cnt_d;
    logic [2:0][4:0]    sb1_q, sb1_d;
    logic [2:0][4:0]    sb2_q, sb2_d;

    logic [31:0]        instr_a, instr_b;
    dec_t               dec_a, dec_b;
    logic               a_present, b_present;
    logic               a_ready, b_ready;
    logic               indep, pair_ok;
    logic [4:0]         dest1, dest2;
    logic               enq;
    logic [PTR_W:0]     enq_cnt, deq_cnt;

    function automatic logic sb_busy(dec_t x,
                                     logic [2:0][4:0] s1,
                                     logic [2:0][4:0] s2);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b = b | src_hits(x, s1[i]) | src_hits(x, s2[i]);
        end
        return b;
    endfunction

    assign instr_a   = mem_q[rd_ptr_q];
    assign instr_b   = mem_q[rd_ptr_q + PTR_W'(1)];
    assign a_present = (cnt_q != '0);
    assign b_present = (cnt_q >= (PTR_W + 1)'(2));

    instr_decode u_dec_a (
        .instr_i (instr_a),
        .dec_o   (dec_a)
    );

    instr_decode u_dec_b (
        .instr_i (instr_b),
        .dec_o   (dec_b)
    );

    assign a_ready = !sb_busy(dec_a, sb1_q, sb2_q);
    assign b_ready = !sb_busy(dec_b, sb1_q, sb2_q);

    // B pairs with A only without RAW on A's result and without WAW.
    assign indep = !src_hits(dec_b, dec_a.dest) &&
                   !((dec_a.dest != 5'd0) && (dec_a.dest == dec_b.dest));
    assign pair_ok = b_present && b_ready && indep;

    always_comb begin
        iss_valid1 = 1'b0;
        iss_valid2 = 1'b0;
        iss_instr1 = NOP;
        iss_instr2 = NOP;
        dest1      = 5'd0;
        dest2      = 5'd0;
        if (!hold && !flush && a_present && a_ready) begin
            unique case (dec_a.cls)
                CLS_BR: begin
                    iss_valid1 = 1'b1;
                    iss_instr1 = instr_a;
                    dest1      = dec_a.dest;
                end
                CLS_MEM: begin
                    iss_valid2 = 1'b1;
                    iss_instr2 = instr_a;
                    dest2      = dec_a.dest;
                    if (pair_ok && dec_b.cls == CLS_ALU) begin
                        iss_valid1 = 1'b1;
                        iss_instr1 = instr_b;
                        dest1      = dec_b.dest;
                    end
                end
                default: begin
                    iss_valid1 = 1'b1;
                    iss_instr1 = instr_a;
                    dest1      = dec_a.dest;
                    if (pair_ok && dec_b.cls != CLS_BR) begin
                        iss_valid2 = 1'b1;
                        iss_instr2 = instr_b;
                        dest2      = dec_b.dest;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (cnt_q <= FILL_MAX);
    assign occupancy = cnt_q;
    assign enq       = in_ready && in_valid1 && !flush;
    assign enq_cnt   = enq ? (in_valid2 ? (PTR_W + 1)'(2) : (PTR_W + 1)'(1))
                           : '0;
    assign deq_cnt   = (PTR_W + 1)'(iss_valid1) + (PTR_W + 1)'(iss_valid2);

    always_comb begin
        rd_ptr_d = rd_ptr_q + deq_cnt[PTR_W-1:0];
        wr_ptr_d = wr_ptr_q + enq_cnt[PTR_W-1:0];
        cnt_d    = cnt_q - deq_cnt + enq_cnt;
        sb1_d    = sb1_q;
        sb2_d    = sb2_q;
        // Older in-flight results keep draining through a flush.
        if (flush || !hold) begin
            sb1_d = {sb1_q[1:0], dest1};
            sb2_d = {sb2_q[1:0], dest2};
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            sb1_q    <= '0;
            sb2_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            sb1_q    <= sb1_d;
            sb2_q    <= sb2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            mem_q[wr_ptr_q] <= in_instr1;
            if (in_valid2) begin
                mem_q[wr_ptr_q + PTR_W'(1)] <= in_instr2;
            end
        end
    end

endmodule
